// File: rtl/uart_prog_loader.sv
// -----------------------------------------------------------------------------
// uart_prog_loader
//
// Parses program-download frames from the UART receiver byte stream and writes
// the decoded 32-bit words into the instruction memory. The CPU is held in
// stall while a frame is in flight. A one-byte ACK/NAK is returned through the
// UART transmit byte interface.
//
// Frame: A5 5A LEN_HI LEN_LO ADDR[31:24..7:0] {N x 4-byte LE word} CSUM
// CSUM = 8-bit wrap-around sum of LEN_HI through the last data byte.
//
// Optional feature (macro UART_LOADER_TIMEOUT_EN): an inter-byte idle counter
// aborts a stalled frame after TIMEOUT_CYCLES idle clocks. Without the macro a
// stalled frame waits indefinitely.
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   rx_valid_i      one-cycle strobe, rx_data_i holds a new byte
//   rx_data_i       received byte
//   tx_valid_o      response byte valid, held until accepted
//   tx_data_o       response byte (ACK_BYTE / NAK_BYTE)
//   tx_ready_i      transmitter accepts when high together with tx_valid_o
//   mem_we_o        one-cycle instruction-memory write strobe
//   mem_waddr_o     word-aligned byte address
//   mem_wdata_o     write data
//   cpu_hold_o      CPU stall request
//   load_done_o     one-cycle pulse when a frame completes with ACK
//   load_err_o      sticky error flag, cleared at the next frame start
// -----------------------------------------------------------------------------
module uart_prog_loader #(
  parameter logic [23:0] TIMEOUT_CYCLES = 24'd1000000,
  parameter logic [7:0]  ACK_BYTE       = 8'h06,
  parameter logic [7:0]  NAK_BYTE       = 8'h15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_valid_i,
  input  logic [7:0]  rx_data_i,
  output logic        tx_valid_o,
  output logic [7:0]  tx_data_o,
  input  logic        tx_ready_i,
  output logic        mem_we_o,
  output logic [31:0] mem_waddr_o,
  output logic [31:0] mem_wdata_o,
  output logic        cpu_hold_o,
  output logic        load_done_o,
  output logic        load_err_o
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_LEN,
    ST_ADDR,
    ST_DATA,
    ST_CSUM,
    ST_RESP
  } state_t;

  localparam logic [7:0] SYNC0 = 8'hA5;
  localparam logic [7:0] SYNC1 = 8'h5A;

  state_t      state_q,     state_d;
  logic [1:0]  byte_cnt_q,  byte_cnt_d;   // byte index within LEN/ADDR/word
  logic [15:0] words_q,     words_d;      // words still to receive
  logic [7:0]  csum_q,      csum_d;
  logic [31:0] addr_q,      addr_d;
  logic [31:0] wdata_q,     wdata_d;
  logic        mem_we_q,    mem_we_d;
  logic        tx_valid_q,  tx_valid_d;
  logic [7:0]  tx_data_q,   tx_data_d;
  logic        cpu_hold_q,  cpu_hold_d;
  logic        load_done_q, load_done_d;
  logic        load_err_q,  load_err_d;

`ifdef UART_LOADER_TIMEOUT_EN
  logic [23:0] tmo_q, tmo_d;
`else
  // Parameter is kept so both builds share one interface; nothing reads it here.
  wire unused_timeout = ^TIMEOUT_CYCLES;
`endif

  always_comb begin
    // NOTE: every _d gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    words_d     = words_q;
    csum_d      = csum_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    mem_we_d    = 1'b0;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    cpu_hold_d  = cpu_hold_q;
    load_done_d = 1'b0;
    load_err_d  = load_err_q;

    // Address advances in the cycle the write strobe is visible, so it is
    // stable for the strobe itself and ready for the next word.
    if (mem_we_q) addr_d = addr_q + 32'd4;

    unique case (state_q)
      ST_IDLE: begin
        if (rx_valid_i && rx_data_i == SYNC0) state_d = ST_SYNC;
      end

      ST_SYNC: begin
        if (rx_valid_i) begin
          if (rx_data_i == SYNC1) begin
            state_d    = ST_LEN;
            load_err_d = 1'b0;
            cpu_hold_d = 1'b1;
            byte_cnt_d = 2'd0;
            words_d    = 16'd0;
            csum_d     = 8'd0;
          end else if (rx_data_i != SYNC0) begin
            state_d = ST_IDLE;
          end
        end
      end

      ST_LEN: begin
        if (rx_valid_i) begin
          csum_d     = csum_q + rx_data_i;
          words_d    = {words_q[7:0], rx_data_i};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd1) begin
            byte_cnt_d = 2'd0;
            if ({words_q[7:0], rx_data_i} == 16'd0) begin
              // Empty frame: nothing to load, reject immediately.
              state_d    = ST_RESP;
              tx_valid_d = 1'b1;
              tx_data_d  = NAK_BYTE;
              load_err_d = 1'b1;
            end else begin
              state_d = ST_ADDR;
            end
          end
        end
      end

      ST_ADDR: begin
        if (rx_valid_i) begin
          csum_d     = csum_q + rx_data_i;
          addr_d     = {addr_q[23:0], rx_data_i};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            addr_d[1:0] = 2'b00;
            state_d     = ST_DATA;
          end
        end
      end

      ST_DATA: begin
        if (rx_valid_i) begin
          csum_d     = csum_q + rx_data_i;
          // Little-endian words: shift in from the top so byte 0 ends at [7:0].
          wdata_d    = {rx_data_i, wdata_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            mem_we_d = 1'b1;
            words_d  = words_q - 16'd1;
            if (words_q == 16'd1) state_d = ST_CSUM;
          end
        end
      end

      ST_CSUM: begin
        if (rx_valid_i) begin
          state_d    = ST_RESP;
          tx_valid_d = 1'b1;
          if (rx_data_i == csum_q) begin
            tx_data_d = ACK_BYTE;
          end else begin
            tx_data_d  = NAK_BYTE;
            load_err_d = 1'b1;
          end
        end
      end

      ST_RESP: begin
        // Received bytes are deliberately dropped here.
        if (tx_ready_i) begin
          state_d     = ST_IDLE;
          tx_valid_d  = 1'b0;
          cpu_hold_d  = 1'b0;
          // Every NAK path sets load_err, so a clear flag means ACK was sent.
          load_done_d = ~load_err_q;
        end
      end

      default: state_d = ST_IDLE;
    endcase

`ifdef UART_LOADER_TIMEOUT_EN
    tmo_d = 24'd0;
    if (state_q != ST_IDLE && state_q != ST_RESP && !rx_valid_i) begin
      if (tmo_q == TIMEOUT_CYCLES - 24'd1) begin
        state_d    = ST_IDLE;
        load_err_d = 1'b1;
        cpu_hold_d = 1'b0;
      end else begin
        tmo_d = tmo_q + 24'd1;
      end
    end
`endif
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge values of the others.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      byte_cnt_q  <= 2'd0;
      words_q     <= 16'd0;
      csum_q      <= 8'd0;
      addr_q      <= 32'd0;
      wdata_q     <= 32'd0;
      mem_we_q    <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= 8'd0;
      cpu_hold_q  <= 1'b0;
      load_done_q <= 1'b0;
      load_err_q  <= 1'b0;
`ifdef UART_LOADER_TIMEOUT_EN
      tmo_q       <= 24'd0;
`endif
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      words_q     <= words_d;
      csum_q      <= csum_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      mem_we_q    <= mem_we_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      cpu_hold_q  <= cpu_hold_d;
      load_done_q <= load_done_d;
      load_err_q  <= load_err_d;
`ifdef UART_LOADER_TIMEOUT_EN
      tmo_q       <= tmo_d;
`endif
    end
  end

  assign tx_valid_o  = tx_valid_q;
  assign tx_data_o   = tx_data_q;
  assign mem_we_o    = mem_we_q;
  assign mem_waddr_o = addr_q;
  assign mem_wdata_o = wdata_q;
  assign cpu_hold_o  = cpu_hold_q;
  assign load_done_o = load_done_q;
  assign load_err_o  = load_err_q;

endmodule
